// File: rtl/lm_sm_sequencer_if.sv
// Decode/memory handshake bundle for the LM/SM/LA/SA transfer sequencer.
// The sequencer takes the slave modport; decode and memory sit behind master.
interface lm_sm_sequencer_if #(
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3
);
    logic                start;
    logic [3:0]          opcode;
    logic [NUM_REGS-1:0] reg_mask;
    logic [ADDR_W-1:0]   base_addr;
    logic                mem_ready;
    logic                busy;
    logic [REG_AW-1:0]   reg_addr;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                done;
    logic [REG_AW:0]     xfer_count;

    modport master (
        output start, opcode, reg_mask, base_addr, mem_ready,
        input  busy, reg_addr, mem_addr, mem_read, mem_write, reg_write, done, xfer_count
    );

    modport slave (
        input  start, opcode, reg_mask, base_addr, mem_ready,
        output busy, reg_addr, mem_addr, mem_read, mem_write, reg_write, done, xfer_count
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask lowest-bit first,
// issuing one memory access per set bit at consecutive addresses.
module lm_sm_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3
) (
    input  logic               clk,
    input  logic               reset,
    lm_sm_sequencer_if.slave   bus
);
    localparam int CNT_W = REG_AW + 1;

    if (DATA_W < 1 || NUM_REGS < 2 || NUM_REGS > 32 || REG_AW != $clog2(NUM_REGS)) begin : g_bad_params
        $error("lm_sm_sequencer: inconsistent DATA_W/NUM_REGS/REG_AW");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                load_q, load_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept;
    logic [NUM_REGS-1:0] mask_sel;
    logic [NUM_REGS-1:0] pend_rest;
    logic [REG_AW-1:0]   low_idx;
    logic                in_xfer;

    // Opcodes 11xx are the only accepted ones; bit1 selects the all-registers form.
    assign accept    = (state_q == S_IDLE) && bus.start && (bus.opcode[3:2] == 2'b11);
    assign mask_sel  = bus.opcode[1] ? '1 : bus.reg_mask;
    assign pend_rest = pend_q & (pend_q - NUM_REGS'(1));
    assign in_xfer   = (state_q == S_XFER);

    always_comb begin
        low_idx = '0;
        for (int unsigned i = NUM_REGS; i > 0; i--) begin
            if (pend_q[i-1]) begin
                low_idx = REG_AW'(i - 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load_d  = ~bus.opcode[0];
                    pend_d  = mask_sel;
                    addr_d  = bus.base_addr;
                    cnt_d   = '0;
                    state_d = (mask_sel != '0) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                if (bus.mem_ready) begin
                    pend_d = pend_rest;
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (pend_rest == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            pend_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from state, so reset clears them without waiting for a clock.
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.reg_addr   = in_xfer ? low_idx : '0;
    assign bus.mem_addr   = in_xfer ? addr_q : '0;
    assign bus.mem_read   = in_xfer & load_q;
    assign bus.mem_write  = in_xfer & ~load_q;
    assign bus.reg_write  = in_xfer & load_q & bus.mem_ready;
    assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed checks of the LM/SM/LA/SA sequencer with hand-computed cycle-by-cycle outputs.
module tb_lm_sm_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lm_sm_sequencer_if #(.ADDR_W(16), .NUM_REGS(8), .REG_AW(3)) bus ();

    lm_sm_sequencer #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .NUM_REGS(8),
        .REG_AW  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (busy,done,rd,wr,rw,raddr,maddr,cnt)", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic b, input logic d, input logic rd, input logic wr,
                                       input logic rw, input logic [2:0] ra, input logic [15:0] ma,
                                       input logic [3:0] cnt);
        return {4'b0, b, d, rd, wr, rw, ra, ma, cnt};
    endfunction

    task automatic expect_out(input string tag, input logic b, input logic d, input logic rd,
                              input logic wr, input logic rw, input logic [2:0] ra,
                              input logic [15:0] ma, input logic [3:0] cnt);
        check(tag, pk(bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.reg_write,
                      bus.reg_addr, bus.mem_addr, bus.xfer_count),
              pk(b, d, rd, wr, rw, ra, ma, cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] mask, input logic [15:0] base);
        bus.start     = 1'b1;
        bus.opcode    = op;
        bus.reg_mask  = mask;
        bus.base_addr = base;
        tick();
        bus.start     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.opcode    = 4'h0;
        bus.reg_mask  = 8'h00;
        bus.base_addr = 16'h0000;
        bus.mem_ready = 1'b0;
        #3;
        expect_out("rst_init", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd0);
        @(posedge clk);
        #1;

        // LM 1010_0001 from 0x40, first edge after reset release accepts
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        issue(4'b1100, 8'hA1, 16'h0040);
        #1 expect_out("lm_c1", 1, 0, 1, 0, 1, 3'd0, 16'h0040, 4'd0);
        tick(); #1 expect_out("lm_c2", 1, 0, 1, 0, 1, 3'd5, 16'h0041, 4'd1);
        tick(); #1 expect_out("lm_c3", 1, 0, 1, 0, 1, 3'd7, 16'h0042, 4'd2);
        tick(); #1 expect_out("lm_done", 1, 1, 0, 0, 0, 3'd0, 16'h0000, 4'd3);
        tick(); #1 expect_out("lm_idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd3);

        // SA from 0x100 with a wait state before every completion
        bus.mem_ready = 1'b0;
        issue(4'b1111, 8'h00, 16'h0100);
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = 1'b0;
            #1 expect_out($sformatf("sa_wait%0d", i), 1, 0, 0, 1, 0, 3'(i), 16'h0100 + 16'(i), 4'(i));
            tick();
            bus.mem_ready = 1'b1;
            #1 expect_out($sformatf("sa_rdy%0d", i), 1, 0, 0, 1, 0, 3'(i), 16'h0100 + 16'(i), 4'(i));
            tick();
        end
        #1 expect_out("sa_done", 1, 1, 0, 0, 0, 3'd0, 16'h0000, 4'd8);
        tick(); #1 expect_out("sa_idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd8);

        // LA from 0xFFFE wraps through zero
        bus.mem_ready = 1'b1;
        issue(4'b1110, 8'h00, 16'hFFFE);
        for (int i = 0; i < 8; i++) begin
            a = 16'(32'hFFFE + i);
            #1 expect_out($sformatf("la_x%0d", i), 1, 0, 1, 0, 1, 3'(i), a, 4'(i));
            tick();
        end
        #1 expect_out("la_done", 1, 1, 0, 0, 0, 3'd0, 16'h0000, 4'd8);
        tick(); #1 expect_out("la_idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd8);

        // LM with empty mask goes straight to DONE
        issue(4'b1100, 8'h00, 16'h1234);
        #1 expect_out("lm0_done", 1, 1, 0, 0, 0, 3'd0, 16'h0000, 4'd0);
        tick(); #1 expect_out("lm0_idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd0);

        // reset after two transfers of an LM
        issue(4'b1100, 8'hFF, 16'h0200);
        #1 expect_out("rlm_c1", 1, 0, 1, 0, 1, 3'd0, 16'h0200, 4'd0);
        tick(); #1 expect_out("rlm_c2", 1, 0, 1, 0, 1, 3'd1, 16'h0201, 4'd1);
        tick();
        reset = 1'b0;
        #1 expect_out("rst_async", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd0);
        tick(); #1 expect_out("rst_hold", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd0);
        reset = 1'b1;
        issue(4'b1100, 8'h06, 16'h0010);
        #1 expect_out("post_c1", 1, 0, 1, 0, 1, 3'd1, 16'h0010, 4'd0);
        tick(); #1 expect_out("post_c2", 1, 0, 1, 0, 1, 3'd2, 16'h0011, 4'd1);
        tick(); #1 expect_out("post_done", 1, 1, 0, 0, 0, 3'd0, 16'h0000, 4'd2);
        tick(); #1 expect_out("post_idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd2);

        // illegal opcode ignored
        issue(4'b0001, 8'hFF, 16'h0300);
        #1 expect_out("bad_op", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd2);
        tick(); #1 expect_out("bad_op2", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd2);

        // start while busy (XFER and DONE) ignored
        bus.mem_ready = 1'b0;
        issue(4'b1100, 8'h03, 16'h0020);
        #1 expect_out("bsy_c1", 1, 0, 1, 0, 0, 3'd0, 16'h0020, 4'd0);
        bus.start     = 1'b1;
        bus.opcode    = 4'b1101;
        bus.reg_mask  = 8'hFF;
        bus.base_addr = 16'h0080;
        tick();
        bus.start = 1'b0;
        #1 expect_out("bsy_start", 1, 0, 1, 0, 0, 3'd0, 16'h0020, 4'd0);
        bus.mem_ready = 1'b1;
        #1 expect_out("bsy_rdy", 1, 0, 1, 0, 1, 3'd0, 16'h0020, 4'd0);
        tick(); #1 expect_out("bsy_c2", 1, 0, 1, 0, 1, 3'd1, 16'h0021, 4'd1);
        tick(); #1 expect_out("bsy_done", 1, 1, 0, 0, 0, 3'd0, 16'h0000, 4'd2);
        bus.start    = 1'b1;
        bus.opcode   = 4'b1100;
        bus.reg_mask = 8'h01;
        tick();
        bus.start = 1'b0;
        #1 expect_out("done_start", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd2);
        tick(); #1 expect_out("done_start2", 0, 0, 0, 0, 0, 3'd0, 16'h0000, 4'd2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
